stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
Timekeeping engine of the stopwatch. It sits directly upstream of the seven-segment display driver and feeds it binary minutes and seconds (0..59 each). It conditions the raw push-buttons, runs an IDLE/RUNNING/PAUSED state machine, and divides the board clock down to a 1 Hz count enable.

Parameters:
CLK_HZ, 100_000_000, clock frequency; prescaler terminal count is CLK_HZ-1.
DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples required before a button level is accepted (10 ms at 100 MHz).

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high; clock clock
btn_start_stop  input  1  raw, asynchronous push-button; press toggles run/pause
btn_clear  input  1  raw, asynchronous push-button; press zeroes the time when not running
minutes  output  6  binary minutes 0..59, registered
seconds  output  6  binary seconds 0..59, registered
running  output  1  high in RUNNING, registered
overflow  output  1  sticky flag; set on 59:59 -> 00:00 wrap, registered

Behaviour:
- Reset (asynchronous): state IDLE; prescaler 0; minutes, seconds, running, overflow all 0; debouncer state cleared.
- Button path, per button:
  - 2-flop synchroniser.
  - Stable counter: the debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - One-cycle press pulse on the debounced rising edge.
  - A release generates no pulse. A held button generates exactly one pulse.
- State machine (acts on the press pulses):
  - IDLE + start -> RUNNING.
  - RUNNING + start -> PAUSED. The prescaler value is held, not cleared.
  - PAUSED + start -> RUNNING. Counting resumes from the held prescaler value.
  - IDLE or PAUSED + clear -> IDLE. Zeroes minutes, seconds, prescaler and overflow.
  - RUNNING + clear: ignored.
  - Start and clear pulses in the same cycle: in RUNNING, start wins (go to PAUSED). In IDLE or PAUSED, clear wins (go to IDLE, no start).
- running = 1 exactly while state is RUNNING. It updates on the clock edge after the pulse cycle.
- Prescaler:
  - Increments only in RUNNING.
  - At CLK_HZ-1 it wraps to 0 and asserts an internal tick for one cycle.
  - First tick after starting from IDLE occurs CLK_HZ cycles after running rises.
- On tick:
  - seconds < 59: seconds+1.
  - seconds = 59: seconds 0, minutes+1.
  - 59:59: both 0, overflow <- 1. Counting continues.
- Outputs are registered and visible the cycle after the tick cycle. minutes and seconds never exceed 59.
- Unused combinations of the state encoding recover to IDLE on the next clock.

Optional Feature:
Macro STOPWATCH_LAP_HOLD_EN.
- Defined:
  - Adds port btn_lap (input, 1, raw) with its own debouncer.
  - In RUNNING, a lap press toggles hold. While held, minutes and seconds show a snapshot taken on the press cycle, and the internal count keeps running.
  - A second lap press releases hold; the outputs show the live count on the next cycle.
  - Hold is cleared by entering IDLE or by reset.
  - Lap presses in IDLE or PAUSED are ignored, and hold persists across pause.
- Undefined: no btn_lap port; the outputs always show the live count.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUNNING=2'd1, ST_PAUSED=2'd2.
  - MAX_SECONDS=59, MAX_MINUTES=59.
  - TIME_W=6.
  - The display driver reuses TIME_W.
- One sub-module is natural: button_debouncer (parameter DEBOUNCE_CYCLES; ports clock, reset, btn_raw, btn_level, btn_press). Instantiated 2 times, or 3 with lap hold.

Test Plan (CLK_HZ=10, DEBOUNCE_CYCLES=4):
- Reset, then a clean start press held 20 cycles -> exactly one press pulse; running=1; after 10 cycles seconds=1, after 600 cycles minutes=1, seconds=0.
- Start press with 3 cycles of bouncing (toggle every 2 cycles) before it settles -> no pulse until 4 stable cycles; exactly one state change.
- Run to 00:07 and press start (PAUSED) -> value holds for 50 cycles. Press start again -> 00:08 arrives with the held prescaler phase preserved. Press clear while RUNNING -> no change.
- Pause at 00:05, then press start and clear so both pulses land in the same cycle -> IDLE at 00:00, running=0.
- Run to 59:59 -> next tick gives 00:00 and overflow=1. Counting continues to 00:01. Pause then clear -> overflow=0.
- Assert reset mid-count at 12:34 -> all outputs 0 and IDLE immediately, without a clock edge. With STOPWATCH_LAP_HOLD_EN: lap at 00:03 holds 00:03 while the count reaches 00:06; a second lap shows 00:06.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and time limits for the stopwatch
package stopwatch_pkg;
  localparam int TIME_W      = 6;
  localparam int MAX_SECONDS = 59;
  localparam int MAX_MINUTES = 59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;
endpackage

// File: rtl/stopwatch_core_debouncer.sv
// rtl/stopwatch_core_debouncer.sv - 2-flop synchroniser, stability counter, press pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] stable_cnt;
  logic             settle;

  // Level flips on the last of DEBOUNCE_CYCLES consecutive differing samples.
  assign settle = (sync_q2 != btn_level) &&
                  (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      btn_level  <= 1'b0;
      btn_press  <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_q1   <= btn_raw;
      sync_q2   <= sync_q1;
      btn_press <= settle && sync_q2;
      if (sync_q2 == btn_level) begin
        stable_cnt <= '0;
      end else if (settle) begin
        btn_level  <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - stopwatch FSM, 1 Hz prescaler and mm:ss counter
// Optional lap hold when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_start_stop,
  input  logic              btn_clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic              btn_lap,
`endif
  output logic [TIME_W-1:0] minutes,
  output logic [TIME_W-1:0] seconds,
  output logic              running,
  output logic              overflow
);
  localparam int PRE_W = $clog2(CLK_HZ + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [TIME_W-1:0] SEC_LAST = TIME_W'(MAX_SECONDS);
  localparam logic [TIME_W-1:0] MIN_LAST = TIME_W'(MAX_MINUTES);

  state_t            state, state_nxt;
  logic [PRE_W-1:0]  presc, presc_nxt;
  logic [TIME_W-1:0] live_min, live_sec, min_nxt, sec_nxt;
  logic              ovf_nxt, tick, do_clear, hold_nxt;
  logic              start_press, clear_press, start_level, clear_level;
  logic              unused_levels;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clock(clock), .reset(reset), .btn_raw(btn_start_stop),
    .btn_level(start_level), .btn_press(start_press)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clock(clock), .reset(reset), .btn_raw(btn_clear),
    .btn_level(clear_level), .btn_press(clear_press)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (!clear_press && start_press) state_nxt = ST_RUNNING;
      ST_RUNNING: if (start_press) state_nxt = ST_PAUSED;
      ST_PAUSED: begin
        if (clear_press)      state_nxt = ST_IDLE;
        else if (start_press) state_nxt = ST_RUNNING;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign do_clear = clear_press && ((state == ST_IDLE) || (state == ST_PAUSED));
  assign tick     = (state == ST_RUNNING) && (presc == PRE_LAST);

  always_comb begin
    presc_nxt = presc;
    sec_nxt   = live_sec;
    min_nxt   = live_min;
    ovf_nxt   = overflow;
    if (do_clear) begin
      presc_nxt = '0;
      sec_nxt   = '0;
      min_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else if (state == ST_RUNNING) begin
      presc_nxt = tick ? '0 : presc + 1'b1;
      if (tick) begin
        if (live_sec != SEC_LAST) begin
          sec_nxt = live_sec + 1'b1;
        end else begin
          sec_nxt = '0;
          if (live_min != MIN_LAST) begin
            min_nxt = live_min + 1'b1;
          end else begin
            min_nxt = '0;
            ovf_nxt = 1'b1;
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap_press, lap_level, hold;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clock(clock), .reset(reset), .btn_raw(btn_lap),
    .btn_level(lap_level), .btn_press(lap_press)
  );

  always_comb begin
    hold_nxt = hold;
    if (state_nxt == ST_IDLE)                      hold_nxt = 1'b0;
    else if (lap_press && (state == ST_RUNNING))   hold_nxt = !hold;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hold <= 1'b0;
    else       hold <= hold_nxt;
  end

  assign unused_levels = ^{start_level, clear_level, lap_level};
`else
  assign hold_nxt      = 1'b0;
  assign unused_levels = ^{start_level, clear_level};
`endif

  // While held the output registers freeze; they equal the live count on the press cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      presc    <= '0;
      live_min <= '0;
      live_sec <= '0;
      minutes  <= '0;
      seconds  <= '0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      live_min <= min_nxt;
      live_sec <= sec_nxt;
      running  <= (state_nxt == ST_RUNNING);
      overflow <= ovf_nxt;
      if (!hold_nxt) begin
        minutes <= min_nxt;
        seconds <= sec_nxt;
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed bench for stopwatch_core (CLK_HZ=10, DEBOUNCE_CYCLES=4)
module tb_stopwatch_core;
  logic       clock = 1'b0;
  logic       reset;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int start_pulses = 0;
  int clear_pulses = 0;
  int sp0;
  int cp0;

  always #5 clock = ~clock;

  stopwatch_core #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock),
    .reset(reset),
    .btn_start_stop(btn_start_stop),
    .btn_clear(btn_clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .btn_lap(btn_lap),
`endif
    .minutes(minutes),
    .seconds(seconds),
    .running(running),
    .overflow(overflow)
  );

  always @(negedge clock) begin
    if (dut.start_press === 1'b1) start_pulses <= start_pulses + 1;
    if (dut.clear_press === 1'b1) clear_pulses <= clear_pulses + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
  endtask

  initial begin
    reset = 1'b1;
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    btn_lap = 1'b0;
    step(2);
    check("rst_minutes", minutes, 0);
    check("rst_seconds", seconds, 0);
    check("rst_running", running, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    step(2);

    // Clean press held 20 cycles; running rises 7 edges after the press.
    sp0 = start_pulses;
    btn_start_stop = 1'b1;
    step(6);
    check("t1_running_before", running, 0);
    step(1);
    check("t1_running_after", running, 1);
    check("t1_one_pulse", start_pulses - sp0, 1);
    step(9);
    check("t1_sec_before_tick", seconds, 0);
    step(1);
    check("t1_sec_first_tick", seconds, 1);
    step(3);
    btn_start_stop = 1'b0;
    step(586);
    check("t1_sec_59", seconds, 59);
    check("t1_min_0", minutes, 0);
    step(1);
    check("t1_min_1", minutes, 1);
    check("t1_sec_0", seconds, 0);
    check("t1_held_one_pulse", start_pulses - sp0, 1);

    // Bouncing press: 2-cycle glitches never satisfy 4 stable samples.
    do_reset();
    sp0 = start_pulses;
    btn_start_stop = 1'b1; step(2);
    btn_start_stop = 1'b0; step(2);
    btn_start_stop = 1'b1; step(2);
    btn_start_stop = 1'b0; step(2);
    btn_start_stop = 1'b1;
    step(5);
    check("t2_no_pulse_yet", start_pulses - sp0, 0);
    step(1);
    check("t2_running_before", running, 0);
    step(1);
    check("t2_running_after", running, 1);
    check("t2_one_pulse", start_pulses - sp0, 1);
    step(10);
    btn_start_stop = 1'b0;
    step(10);

    // Pause at 00:07, prescaler phase held across pause.
    for (int i = 0; i < 200; i++) begin
      if (seconds == 6'd7) break;
      step(1);
    end
    check("t3_reach_7", seconds, 7);
    btn_start_stop = 1'b1;
    step(7);
    check("t3_paused", running, 0);
    step(3);
    btn_start_stop = 1'b0;
    step(40);
    check("t3_hold_sec", seconds, 7);
    check("t3_hold_min", minutes, 0);
    step(10);
    btn_start_stop = 1'b1;
    step(9);
    check("t3_resumed", running, 1);
    check("t3_sec_before_8", seconds, 7);
    step(1);
    check("t3_sec_8_phase", seconds, 8);
    step(2);
    btn_start_stop = 1'b0;
    cp0 = clear_pulses;
    btn_clear = 1'b1;
    step(10);
    btn_clear = 1'b0;
    step(3);
    check("t3_clear_pulse_seen", clear_pulses - cp0, 1);
    check("t3_clear_ignored_run", running, 1);
    check("t3_clear_ignored_sec", seconds, 9);

    // Pause at 00:05 then start+clear on the same cycle: clear wins.
    do_reset();
    btn_start_stop = 1'b1;
    step(20);
    btn_start_stop = 1'b0;
    step(37);
    check("t4_sec_5", seconds, 5);
    btn_start_stop = 1'b1;
    step(13);
    check("t4_paused", running, 0);
    check("t4_paused_sec", seconds, 5);
    btn_start_stop = 1'b0;
    step(10);
    sp0 = start_pulses;
    cp0 = clear_pulses;
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    step(6);
    check("t4_sec_before_clear", seconds, 5);
    step(1);
    check("t4_cleared_sec", seconds, 0);
    check("t4_cleared_min", minutes, 0);
    check("t4_idle", running, 0);
    check("t4_start_pulse", start_pulses - sp0, 1);
    check("t4_clear_pulse", clear_pulses - cp0, 1);
    step(20);
    check("t4_still_idle", running, 0);
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    step(10);

    // Wrap 59:59 -> 00:00 with sticky overflow; pause then clear drops it.
    btn_start_stop = 1'b1;
    step(20);
    btn_start_stop = 1'b0;
    step(35977);
    check("t5_min_59", minutes, 59);
    check("t5_sec_59", seconds, 59);
    check("t5_ovf_before", overflow, 0);
    step(9);
    check("t5_sec_59_late", seconds, 59);
    step(1);
    check("t5_wrap_min", minutes, 0);
    check("t5_wrap_sec", seconds, 0);
    check("t5_ovf_set", overflow, 1);
    step(10);
    check("t5_sec_1", seconds, 1);
    check("t5_ovf_sticky", overflow, 1);
    step(3);
    btn_start_stop = 1'b1;
    step(10);
    check("t5_paused", running, 0);
    btn_start_stop = 1'b0;
    step(10);
    btn_clear = 1'b1;
    step(6);
    check("t5_ovf_before_clear", overflow, 1);
    step(1);
    check("t5_ovf_cleared", overflow, 0);
    check("t5_sec_cleared", seconds, 0);
    step(10);
    btn_clear = 1'b0;
    step(10);

    // Asynchronous reset mid-count at 12:34.
    btn_start_stop = 1'b1;
    step(20);
    btn_start_stop = 1'b0;
    step(7530);
    check("t6_min_12", minutes, 12);
    check("t6_sec_34", seconds, 34);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_min", minutes, 0);
    check("t6_async_sec", seconds, 0);
    check("t6_async_run", running, 0);
    check("t6_async_ovf", overflow, 0);
    step(2);
    reset = 1'b0;
    step(2);

`ifdef STOPWATCH_LAP_HOLD_EN
    // Lap at 00:03 holds while the live count advances to 00:06.
    btn_start_stop = 1'b1;
    step(20);
    btn_start_stop = 1'b0;
    step(17);
    check("lap_sec_3", seconds, 3);
    btn_lap = 1'b1;
    step(13);
    check("lap_held_early", seconds, 3);
    btn_lap = 1'b0;
    step(10);
    btn_lap = 1'b1;
    step(6);
    check("lap_held_late", seconds, 3);
    step(1);
    check("lap_released", seconds, 6);
    check("lap_running", running, 1);
    btn_lap = 1'b0;
    step(10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
